// File: rtl/p32_ling_subtractor_pipe.sv
// p32_ling_subtractor_pipe
// Three-stage elastic 32-bit subtractor: diff = a - b, computed as a + ~b + 1
// through a sparse-2 prefix carry tree (pairs -> 4-bit groups -> group carries).
// Produces borrow, signed-overflow and zero flags alongside the difference.
// Optional build macro P32_SUB_ADD_MODE_EN adds the op_add port: op_add = 1
// computes a + b (carry-in 0, borrow output then reports the carry-out).
module p32_ling_subtractor_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef P32_SUB_ADD_MODE_EN
    input  logic             op_add,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    generate
        if (WIDTH != 32) begin : g_width_check
            $error("p32_ling_subtractor_pipe supports WIDTH = 32 only");
        end
    endgenerate

    logic op_in;
`ifdef P32_SUB_ADD_MODE_EN
    assign op_in = op_add;
`else
    assign op_in = 1'b0;
`endif

    // Stage enables: a stage loads when the stage after it is empty or draining.
    logic en1, en2, en3;
    logic vld_p1_q, vld_p2_q, out_valid_q;

    assign en3      = ~out_valid_q | out_ready;
    assign en2      = ~vld_p2_q | en3;
    assign en1      = ~vld_p1_q | en2;
    assign in_ready = en1 & ~rst;

    // ---------------- S1: operand capture ----------------
    // Only bit 31 of a and b' travels further; the rest is folded into g/p/x.
    logic [WIDTH-1:0] bn_d, g_p1_d, p_p1_d, x_p1_d;
    logic [WIDTH-1:0] g_p1_q, p_p1_q, x_p1_q;
    logic             a31_p1_q, bn31_p1_q, cin_p1_q;

    // Per-bit generate/propagate/half-sum on the (optionally inverted) subtrahend.
    always_comb begin
        bn_d   = op_in ? b : ~b;
        g_p1_d = a & bn_d;
        p_p1_d = a | bn_d;
        x_p1_d = a ^ bn_d;
    end

    // S1 valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else if (en1) begin
            vld_p1_q <= in_valid;
        end
    end

    // S1 data capture; holds while the stage is stalled.
    always_ff @(posedge clk) begin
        if (en1 && in_valid) begin
            g_p1_q    <= g_p1_d;
            p_p1_q    <= p_p1_d;
            x_p1_q    <= x_p1_d;
            a31_p1_q  <= a[WIDTH-1];
            bn31_p1_q <= bn_d[WIDTH-1];
            cin_p1_q  <= ~op_in;
        end
    end

    // ---------------- S2: prefix levels 1 and 2 ----------------
    logic [15:0] g1_pair, p1_pair;
    logic [7:0]  g1e_p2_d, p1e_p2_d, g2_p2_d, p2_p2_d;
    logic [15:0] g0_p2_d, p0_p2_d;

    logic [7:0]       g1e_p2_q, p1e_p2_q, g2_p2_q, p2_p2_q;
    logic [15:0]      g0_p2_q, p0_p2_q;
    logic [WIDTH-1:0] x_p2_q;
    logic             a31_p2_q, bn31_p2_q, cin_p2_q;

    // Pairwise (G1/P1) then 4-bit group (G2/P2) generate and propagate.
    always_comb begin
        g1_pair  = '0;
        p1_pair  = '0;
        g0_p2_d  = '0;
        p0_p2_d  = '0;
        g1e_p2_d = '0;
        p1e_p2_d = '0;
        g2_p2_d  = '0;
        p2_p2_d  = '0;
        for (int i = 0; i < 16; i++) begin
            g1_pair[i] = g_p1_q[2*i+1] | (p_p1_q[2*i+1] & g_p1_q[2*i]);
            p1_pair[i] = p_p1_q[2*i+1] & p_p1_q[2*i];
            g0_p2_d[i] = g_p1_q[2*i];
            p0_p2_d[i] = p_p1_q[2*i];
        end
        for (int j = 0; j < 8; j++) begin
            g2_p2_d[j]  = g1_pair[2*j+1] | (p1_pair[2*j+1] & g1_pair[2*j]);
            p2_p2_d[j]  = p1_pair[2*j+1] & p1_pair[2*j];
            g1e_p2_d[j] = g1_pair[2*j];
            p1e_p2_d[j] = p1_pair[2*j];
        end
    end

    // S2 valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
        end else if (en2) begin
            vld_p2_q <= vld_p1_q;
        end
    end

    // S2 data registers; carry the even-pair terms needed for the odd-pair carries.
    always_ff @(posedge clk) begin
        if (en2 && vld_p1_q) begin
            g1e_p2_q  <= g1e_p2_d;
            p1e_p2_q  <= p1e_p2_d;
            g2_p2_q   <= g2_p2_d;
            p2_p2_q   <= p2_p2_d;
            g0_p2_q   <= g0_p2_d;
            p0_p2_q   <= p0_p2_d;
            x_p2_q    <= x_p1_q;
            a31_p2_q  <= a31_p1_q;
            bn31_p2_q <= bn31_p1_q;
            cin_p2_q  <= cin_p1_q;
        end
    end

    // ---------------- S3: group carries, sparse sum, flags ----------------
    logic [8:0]       c4;
    logic [WIDTH-1:0] carry, sum_d;
    logic             cpair;
    logic             borrow_d, ovf_d, zero_d;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, ovf_q, zero_q;

    // Carry into each 4-bit group (carry-in acts as g[-1]), expanded back to
    // pair carries and then to per-bit carries for the final sum.
    always_comb begin
        c4    = '0;
        carry = '0;
        cpair = 1'b0;
        c4[0] = cin_p2_q;
        for (int j = 0; j < 8; j++) begin
            c4[j+1] = g2_p2_q[j] | (p2_p2_q[j] & c4[j]);
        end
        for (int i = 0; i < 16; i++) begin
            if ((i % 2) == 0) begin
                cpair = c4[i/2];
            end else begin
                cpair = g1e_p2_q[i/2] | (p1e_p2_q[i/2] & c4[i/2]);
            end
            carry[2*i]   = cpair;
            carry[2*i+1] = g0_p2_q[i] | (p0_p2_q[i] & cpair);
        end
        sum_d    = x_p2_q ^ carry;
        // In subtract mode a clear carry-out means a < b.
        borrow_d = cin_p2_q ? ~c4[8] : c4[8];
        // Overflow of a + b': operands agree in sign, result does not.
        ovf_d    = ~(a31_p2_q ^ bn31_p2_q) & (a31_p2_q ^ sum_d[WIDTH-1]);
        zero_d   = ~|sum_d;
    end

    // Output register; holds result and flags while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (en3) begin
            out_valid_q <= vld_p2_q;
            if (vld_p2_q) begin
                diff_q   <= sum_d;
                borrow_q <= borrow_d;
                ovf_q    <= ovf_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_p32_ling_subtractor_pipe.sv
// Testbench for p32_ling_subtractor_pipe: vector table, latency, backpressure,
// mid-stream reset and random traffic checked through an in-order scoreboard.
module tb_p32_ling_subtractor_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        br;
        logic        ov;
        logic        z;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic        borrow, ovf, zero, op;
    logic [31:0] a, b, diff;

    exp_t        q[$];
    exp_t        exp_cur, mon_e, hold_v;
    vec_t        vt[$];
    int          total = 0;
    int          bad   = 0;
    int          lat, idx, cyc, stale;
    bit          rnd_done;
    logic [31:0] ra, rb;
    logic        ro;
    logic [31:0] pa[10];
    logic [31:0] pb[10];

`ifdef P32_SUB_ADD_MODE_EN
    localparam int NRND = 1000;
`else
    localparam int NRND = 400;
`endif

    always #5 clk = ~clk;

    p32_ling_subtractor_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef P32_SUB_ADD_MODE_EN
        .op_add    (op),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Reference: 33-bit unsigned for carry/borrow, sign-extended for overflow.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mop);
        exp_t               m;
        logic        [32:0] u;
        logic signed [32:0] s;
        if (mop) begin
            u = {1'b0, ma} + {1'b0, mb};
            s = $signed({ma[31], ma}) + $signed({mb[31], mb});
        end else begin
            u = {1'b0, ma} - {1'b0, mb};
            s = $signed({ma[31], ma}) - $signed({mb[31], mb});
        end
        m.d  = u[31:0];
        m.br = u[32];
        m.ov = s[32] ^ s[31];
        m.z  = (u[31:0] == 32'h0);
        return m;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] c[4];
        c[0] = 32'h0000_0000;
        c[1] = 32'hFFFF_FFFF;
        c[2] = 32'h8000_0000;
        c[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on retired output.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (in_valid && in_ready) q.push_back(exp_cur);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 64'(q.size()), 64'd1);
                end else begin
                    mon_e = q.pop_front();
                    check("scoreboard", 64'({diff, borrow, ovf, zero}), 64'(mon_e));
                end
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tbv, input logic top, input exp_t e);
        int n;
        bit ok;
        a        = ta;
        b        = tbv;
        op       = top;
        exp_cur  = e;
        in_valid = 1'b1;
        n        = 0;
        ok       = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready && !rst;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        vt.push_back('{32'h0000_0005, 32'h0000_0003, 1'b0, '{32'h0000_0002, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{32'h0000_0000, 32'h0000_0001, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}});
        vt.push_back('{32'h1234_5678, 32'h1234_5678, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}});
        vt.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}});
        vt.push_back('{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{32'h8000_0000, 1'b1, 1'b1, 1'b0}});
        vt.push_back('{32'h0000_0000, 32'h8000_0000, 1'b0, '{32'h8000_0000, 1'b1, 1'b1, 1'b0}});
        vt.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}});
        vt.push_back('{32'h0001_0000, 32'h0000_FFFF, 1'b0, '{32'h0000_0001, 1'b0, 1'b0, 1'b0}});
`ifdef P32_SUB_ADD_MODE_EN
        vt.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}});
        vt.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b1, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        out_ready = 1'b1;
        exp_cur   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({diff, borrow, ovf, zero}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency, counted from the handshake cycle as cycle 0.
        send(32'h5, 32'h3, 1'b0, model(32'h5, 32'h3, 1'b0));
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency_cycles", 64'(lat), 64'd3);
        drain();

        // Directed vector table, back to back.
        foreach (vt[i]) send(vt[i].a, vt[i].b, vt[i].op, vt[i].e);
        drain();

        // Backpressure: consumer stalled for the first 5 cycles of a 10-pair stream.
        for (int i = 0; i < 10; i++) begin
            pa[i] = pick();
            pb[i] = pick();
        end
        idx = 0;
        cyc = 0;
        op  = 1'b0;
        while (idx < 10 && cyc < 100) begin
            a         = pa[idx];
            b         = pb[idx];
            exp_cur   = model(pa[idx], pb[idx], 1'b0);
            in_valid  = 1'b1;
            out_ready = (cyc >= 5);
            @(negedge clk);
            if (cyc == 3) begin
                check("bp_in_ready_full", 64'(in_ready), 64'd0);
                check("bp_accepts_before_full", 64'(idx), 64'd3);
                check("bp_out_valid_stalled", 64'(out_valid), 64'd1);
                hold_v = {diff, borrow, ovf, zero};
            end
            if (cyc == 4) begin
                check("bp_in_ready_held", 64'(in_ready), 64'd0);
                check("bp_output_stable", 64'({diff, borrow, ovf, zero}), 64'(hold_v));
            end
            if (in_ready) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_all_accepted", 64'(idx), 64'd10);
        drain();

        // Reset with two entries in flight; the offer during reset must be refused.
        send(32'hAAAA_0000, 32'h0000_5555, 1'b0, model(32'hAAAA_0000, 32'h0000_5555, 1'b0));
        send(32'h0000_0010, 32'h0000_0020, 1'b0, model(32'h0000_0010, 32'h0000_0020, 1'b0));
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h1;
        b        = 32'h1;
        exp_cur  = model(32'h1, 32'h1, 1'b0);
        @(negedge clk);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_outputs", 64'({diff, borrow, ovf, zero}), 64'd0);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_mid_no_stale", 64'(stale), 64'd0);
        @(posedge clk);
        #1;

        // Random traffic with random input gaps and random consumer stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < NRND; i++) begin
                    ra = pick();
                    rb = pick();
`ifdef P32_SUB_ADD_MODE_EN
                    ro = 1'($urandom_range(0, 1));
`else
                    ro = 1'b0;
`endif
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(ra, rb, ro, model(ra, rb, ro));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
